// File: rtl/phone_cmd_pkg.sv
// Shared constants and types for the phone command receiver.
package phone_cmd_pkg;

    localparam int unsigned MAX_LEN = 4;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [7:0] {
        CMD_SET_HR     = 8'h01,
        CMD_SET_ASSIST = 8'h02,
        CMD_SET_LIGHTS = 8'h03,
        CMD_PING       = 8'h04
    } cmd_e;

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_EXEC,
        S_RESP
    } state_e;

    typedef logic [MAX_LEN-1:0][7:0] payload_t;

endpackage

// File: rtl/phone_cmd_rx_if.sv
// Byte stream in from the UART receiver and ACK/NAK handshake out to the TX arbiter.
interface phone_cmd_rx_if;
    logic       received;
    logic [7:0] rx_byte;
    logic       resp_valid;
    logic [7:0] resp_byte;
    logic       resp_ready;

    modport master (
        input  received,
        input  rx_byte,
        input  resp_ready,
        output resp_valid,
        output resp_byte
    );

    modport slave (
        output received,
        output rx_byte,
        output resp_ready,
        input  resp_valid,
        input  resp_byte
    );
endinterface

// File: rtl/timeout_counter.sv
// Inter-byte watchdog: counts enabled idle cycles, flags the terminal count.
module timeout_counter #(
    parameter int unsigned TERMINAL = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;

    logic [CW-1:0] count;

    assign expired = enable && (count == CW'(TERMINAL - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/phone_cmd_rx.sv
// Frames and validates inbound phone commands, applies rider settings and
// returns a one-byte ACK/NAK through a valid/ready handshake.
module phone_cmd_rx
    import phone_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter int unsigned HR_MIN      = 60,
    parameter int unsigned HR_MAX      = 220,
    parameter int unsigned HR_DEFAULT  = 200
) (
    input  logic                 c50M,
    input  logic                 reset,
    phone_cmd_rx_if.master       link,
    output logic [7:0]           heart_cap,
    output logic [2:0]           assist_level,
    output logic [3:0]           light_mask,
    output logic                 cmd_strobe,
    output logic [7:0]           err_count
);
    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [2:0] len_q, len_d;
    logic [1:0] idx_q, idx_d;
    payload_t   payload_q, payload_d;
    logic [7:0] xor_q, xor_d;
    logic       chk_ok_q, chk_ok_d;
    logic [7:0] heart_d;
    logic [2:0] assist_d;
    logic [3:0] light_d;
    logic       strobe_d;
    logic       resp_valid_q, resp_valid_d;
    logic [7:0] resp_byte_q, resp_byte_d;
    logic [7:0] err_d;
    logic       err_inc;
    logic       frame_ok;
    logic       timer_run;
    logic       expired;
    logic [7:0] value;

    assign link.resp_valid = resp_valid_q;
    assign link.resp_byte  = resp_byte_q;

    assign timer_run = state_q inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK};

    timeout_counter #(.TERMINAL(TIMEOUT_CYC)) u_timeout (
        .clk     (c50M),
        .reset   (reset),
        .clear   (link.received),
        .enable  (timer_run),
        .expired (expired)
    );

    // Single-byte commands carry their value in the last payload slot.
    assign value = payload_q[2'(len_q - 3'd1)];

    always_comb begin
        frame_ok = 1'b0;
        case (cmd_q)
            CMD_SET_HR:     frame_ok = (len_q == 3'd1) && (value >= 8'(HR_MIN)) && (value <= 8'(HR_MAX));
            CMD_SET_ASSIST: frame_ok = (len_q == 3'd1) && (value <= 8'd7);
            CMD_SET_LIGHTS: frame_ok = (len_q == 3'd1) && (value[7:4] == 4'h0);
            CMD_PING:       frame_ok = (len_q == 3'd0);
            default:        frame_ok = 1'b0;
        endcase
        frame_ok = frame_ok && chk_ok_q;
    end

    // Next-state and next-register logic; timeout expiry overrides any byte.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        len_d        = len_q;
        idx_d        = idx_q;
        payload_d    = payload_q;
        xor_d        = xor_q;
        chk_ok_d     = chk_ok_q;
        heart_d      = heart_cap;
        assist_d     = assist_level;
        light_d      = light_mask;
        strobe_d     = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_byte_d  = resp_byte_q;
        err_inc      = 1'b0;

        if (expired) begin
            state_d = S_HUNT;
            err_inc = 1'b1;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (link.received && (link.rx_byte == SYNC_BYTE)) begin
                        state_d = S_CMD;
                        xor_d   = 8'h00;
                    end
                end
                S_CMD: begin
                    if (link.received) begin
                        cmd_d   = link.rx_byte;
                        xor_d   = xor_q ^ link.rx_byte;
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (link.received) begin
                        if (link.rx_byte > 8'(MAX_LEN)) begin
                            err_inc = 1'b1;
                            state_d = S_HUNT;
                        end else begin
                            len_d   = link.rx_byte[2:0];
                            xor_d   = xor_q ^ link.rx_byte;
                            idx_d   = 2'd0;
                            state_d = (link.rx_byte == 8'h00) ? S_CHK : S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (link.received) begin
                        payload_d[idx_q] = link.rx_byte;
                        xor_d            = xor_q ^ link.rx_byte;
                        idx_d            = idx_q + 2'd1;
                        if (({1'b0, idx_q} + 3'd1) == len_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (link.received) begin
                        chk_ok_d = (link.rx_byte == xor_q);
                        state_d  = S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                    if (frame_ok) begin
                        strobe_d    = 1'b1;
                        resp_byte_d = ACK_BYTE;
                        case (cmd_q)
                            CMD_SET_HR:     heart_d  = value;
                            CMD_SET_ASSIST: assist_d = value[2:0];
                            CMD_SET_LIGHTS: light_d  = value[3:0];
                            default:        ;
                        endcase
                    end else begin
                        err_inc     = 1'b1;
                        resp_byte_d = NAK_BYTE;
                    end
                end
                S_RESP: begin
                    if (link.resp_ready) begin
                        resp_valid_d = 1'b0;
                        state_d      = S_HUNT;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end

        err_d = (err_inc && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
    end

    always_ff @(posedge c50M) begin
        if (reset) begin
            state_q      <= S_HUNT;
            cmd_q        <= 8'h00;
            len_q        <= 3'd0;
            idx_q        <= 2'd0;
            payload_q    <= '0;
            xor_q        <= 8'h00;
            chk_ok_q     <= 1'b0;
            heart_cap    <= 8'(HR_DEFAULT);
            assist_level <= 3'd0;
            light_mask   <= 4'h0;
            cmd_strobe   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_byte_q  <= 8'h00;
            err_count    <= 8'h00;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            payload_q    <= payload_d;
            xor_q        <= xor_d;
            chk_ok_q     <= chk_ok_d;
            heart_cap    <= heart_d;
            assist_level <= assist_d;
            light_mask   <= light_d;
            cmd_strobe   <= strobe_d;
            resp_valid_q <= resp_valid_d;
            resp_byte_q  <= resp_byte_d;
            err_count    <= err_d;
        end
    end
endmodule

// File: tb/tb_phone_cmd_rx.sv
// Directed bench for phone_cmd_rx: table of frames plus hand-written
// sequences for timeout, oversize LEN, mid-frame reset and error saturation.
module tb_phone_cmd_rx;
    import phone_cmd_pkg::*;

    localparam int unsigned TO = 100;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    phone_cmd_rx_if bus();

    logic [7:0] heart_cap;
    logic [2:0] assist_level;
    logic [3:0] light_mask;
    logic       cmd_strobe;
    logic [7:0] err_count;

    phone_cmd_rx #(.TIMEOUT_CYC(TO)) dut (
        .c50M         (clk),
        .reset        (reset),
        .link         (bus),
        .heart_cap    (heart_cap),
        .assist_level (assist_level),
        .light_mask   (light_mask),
        .cmd_strobe   (cmd_strobe),
        .err_count    (err_count)
    );

    typedef struct {
        logic [0:7][7:0] f;
        int              n;
        logic [7:0]      resp;
        logic [7:0]      hr;
        logic [2:0]      asl;
        logic [3:0]      lm;
        logic [7:0]      err;
        int              stall;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_hr  = 8'd200;
    logic [2:0] m_as  = 3'd0;
    logic [3:0] m_lm  = 4'h0;
    logic [7:0] m_err = 8'd0;

    vec_t tbl [17];

    function automatic vec_t mkv(input logic [63:0] f, input int n, input logic [7:0] resp,
                                 input logic [7:0] hr, input logic [2:0] asl, input logic [3:0] lm,
                                 input logic [7:0] err, input int stall);
        vec_t v;
        v.f = f; v.n = n; v.resp = resp; v.hr = hr; v.asl = asl; v.lm = lm; v.err = err; v.stall = stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.received = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.received = 1'b0;
        bus.rx_byte  = 8'h00;
    endtask

    task automatic idle_no_resp(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk(name, 32'(bus.resp_valid), 32'd0);
        end
    endtask

    task automatic run_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) send(v.f[i]);
        chk("exec_valid", 32'(bus.resp_valid), 32'd0);
        chk("exec_hr_old", 32'(heart_cap), 32'(m_hr));
        chk("exec_strobe", 32'(cmd_strobe), 32'd0);
        @(negedge clk);
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_byte", 32'(bus.resp_byte), 32'(v.resp));
        chk("cmd_strobe", 32'(cmd_strobe), 32'(v.resp == ACK_BYTE));
        chk("heart_cap", 32'(heart_cap), 32'(v.hr));
        chk("assist_level", 32'(assist_level), 32'(v.asl));
        chk("light_mask", 32'(light_mask), 32'(v.lm));
        chk("err_count", 32'(err_count), 32'(v.err));
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_byte", 32'(bus.resp_byte), 32'(v.resp));
            chk("strobe_once", 32'(cmd_strobe), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_done", 32'(bus.resp_valid), 32'd0);
        chk("strobe_low", 32'(cmd_strobe), 32'd0);
        m_hr = v.hr; m_as = v.asl; m_lm = v.lm; m_err = v.err;
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_hr"}, 32'(heart_cap), 32'd200);
        chk({name, "_as"}, 32'(assist_level), 32'd0);
        chk({name, "_lm"}, 32'(light_mask), 32'd0);
        chk({name, "_strobe"}, 32'(cmd_strobe), 32'd0);
        chk({name, "_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({name, "_byte"}, 32'(bus.resp_byte), 32'd0);
        chk({name, "_err"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        bus.received   = 1'b0;
        bus.rx_byte    = 8'h00;
        bus.resp_ready = 1'b0;

        //                  frame bytes            n  resp      hr     as    lm     err   stall
        tbl[0]  = mkv(64'hA501019696000000, 5, ACK_BYTE, 8'h96, 3'd0, 4'h0, 8'd0, 0);
        tbl[1]  = mkv(64'hA502010506000000, 5, ACK_BYTE, 8'h96, 3'd5, 4'h0, 8'd0, 20);
        tbl[2]  = mkv(64'hA503010300000000, 5, NAK_BYTE, 8'h96, 3'd5, 4'h0, 8'd1, 0);
        tbl[3]  = mkv(64'hA50101DCDC000000, 5, ACK_BYTE, 8'hDC, 3'd5, 4'h0, 8'd1, 0);
        tbl[4]  = mkv(64'hA50101DDDD000000, 5, NAK_BYTE, 8'hDC, 3'd5, 4'h0, 8'd2, 0);
        tbl[5]  = mkv(64'hA501013C3C000000, 5, ACK_BYTE, 8'h3C, 3'd5, 4'h0, 8'd2, 0);
        tbl[6]  = mkv(64'hA501013B3B000000, 5, NAK_BYTE, 8'h3C, 3'd5, 4'h0, 8'd3, 0);
        tbl[7]  = mkv(64'hA503010A08000000, 5, ACK_BYTE, 8'h3C, 3'd5, 4'hA, 8'd3, 0);
        tbl[8]  = mkv(64'hA503011A18000000, 5, NAK_BYTE, 8'h3C, 3'd5, 4'hA, 8'd4, 0);
        tbl[9]  = mkv(64'hA502010704000000, 5, ACK_BYTE, 8'h3C, 3'd7, 4'hA, 8'd4, 0);
        tbl[10] = mkv(64'hA50201080B000000, 5, NAK_BYTE, 8'h3C, 3'd7, 4'hA, 8'd5, 0);
        tbl[11] = mkv(64'h1234A50400040000, 6, ACK_BYTE, 8'h3C, 3'd7, 4'hA, 8'd5, 0);
        tbl[12] = mkv(64'hA504010005000000, 5, NAK_BYTE, 8'h3C, 3'd7, 4'hA, 8'd6, 0);
        tbl[13] = mkv(64'hA507000700000000, 4, NAK_BYTE, 8'h3C, 3'd7, 4'hA, 8'd7, 0);
        tbl[14] = mkv(64'hA502020300030000, 6, NAK_BYTE, 8'h3C, 3'd7, 4'hA, 8'd8, 0);
        tbl[15] = mkv(64'hA50404A5010203A5, 8, NAK_BYTE, 8'h3C, 3'd7, 4'hA, 8'd9, 0);
        tbl[16] = mkv(64'hA503010002000000, 5, ACK_BYTE, 8'h3C, 3'd7, 4'h0, 8'd9, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");

        foreach (tbl[i]) run_frame(tbl[i]);

        // LEN above 4: error, no response, then a normal frame still works.
        send(8'hA5); send(8'h01); send(8'h05);
        chk("biglen_err", 32'(err_count), 32'd10);
        idle_no_resp(4, "biglen_no_resp");
        m_err = 8'd10;
        run_frame(mkv(64'hA504000400000000, 4, ACK_BYTE, m_hr, m_as, m_lm, m_err, 0));

        // Idle timeout: expiry lands exactly TO cycles after the last byte.
        send(8'hA5); send(8'h04);
        repeat (TO - 1) @(negedge clk);
        chk("to_before_err", 32'(err_count), 32'd10);
        chk("to_before_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        chk("to_after_err", 32'(err_count), 32'd11);
        idle_no_resp(3, "to_no_resp");
        m_err = 8'd11;
        run_frame(mkv(64'hA504000400000000, 4, ACK_BYTE, m_hr, m_as, m_lm, m_err, 0));

        // Byte arriving in the expiry cycle is dropped; the rest is hunted past.
        send(8'hA5); send(8'h04);
        repeat (TO - 1) @(negedge clk);
        send(8'h00);
        chk("to_coinc_err", 32'(err_count), 32'd12);
        send(8'h04);
        idle_no_resp(3, "to_coinc_no_resp");
        chk("to_coinc_err2", 32'(err_count), 32'd12);
        m_err = 8'd12;
        run_frame(mkv(64'hA504000400000000, 4, ACK_BYTE, m_hr, m_as, m_lm, m_err, 0));

        // Reset in the middle of a SET_HR payload.
        send(8'hA5); send(8'h01); send(8'h02); send(8'h96);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("midreset");
        send(8'h01); send(8'h97);
        idle_no_resp(3, "midreset_no_resp");
        chk("midreset_hr", 32'(heart_cap), 32'd200);
        m_hr = 8'd200; m_as = 3'd0; m_lm = 4'h0; m_err = 8'd0;
        run_frame(mkv(64'hA504000400000000, 4, ACK_BYTE, m_hr, m_as, m_lm, m_err, 0));

        // Reset while a response is pending drops it.
        send(8'hA5); send(8'h04); send(8'h00); send(8'h04);
        @(negedge clk);
        chk("pend_valid", 32'(bus.resp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("pendreset");

        // 256 rejected frames saturate the error counter.
        for (int i = 0; i < 256; i++) begin
            run_frame(mkv(64'hA507000700000000, 4, NAK_BYTE, m_hr, m_as, m_lm,
                          (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1, 0));
        end
        chk("sat_err", 32'(err_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
